// File: rtl/div_pkg.sv
// rtl/div_pkg.sv - shared types and widths for the MAC-inverse divider
package div_pkg;

    localparam int DIV_WIDTH     = 8;
    localparam int DIV_OUT_WIDTH = 2 * DIV_WIDTH;
    localparam int CNT_W         = $clog2(DIV_OUT_WIDTH);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } div_state_t;

endpackage

// File: rtl/mac_divider_if.sv
// rtl/mac_divider_if.sv - operand/result bundle between the MAC stage and the divider
interface mac_divider_if
    import div_pkg::*;
#(
    parameter int WIDTH     = DIV_WIDTH,
    parameter int OUT_WIDTH = DIV_OUT_WIDTH
);

    logic                 start;
    logic [OUT_WIDTH-1:0] DATA_IN;
    logic [WIDTH-1:0]     B;
    logic [OUT_WIDTH-1:0] Q;
    logic [WIDTH-1:0]     R;
    logic                 busy;
    logic                 done;
    logic                 div_zero;
    logic                 overflow;

    modport master (
        output start, DATA_IN, B,
        input  Q, R, busy, done, div_zero, overflow
    );

    modport slave (
        input  start, DATA_IN, B,
        output Q, R, busy, done, div_zero, overflow
    );

endinterface

// File: rtl/div_step.sv
// rtl/div_step.sv - one combinational restoring-division step
module div_step #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH:0]   rem_i,
    input  logic             bit_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic [WIDTH:0]   rem_o,
    output logic             qbit_o
);

    logic [WIDTH+1:0] shifted;
    logic [WIDTH+1:0] diff;

    // The partial remainder is always below 2*B, so the extra top bit of diff
    // acts as the borrow/sign of the trial subtraction.
    assign shifted = {rem_i, bit_i};
    assign diff    = shifted - {2'b00, divisor_i};
    assign qbit_o  = ~diff[WIDTH+1];
    assign rem_o   = qbit_o ? diff[WIDTH:0] : shifted[WIDTH:0];

endmodule

// File: rtl/mac_divider.sv
// rtl/mac_divider.sv - sequential restoring divider recovering A and C from D = A*B + C
module mac_divider
    import div_pkg::*;
#(
    parameter int WIDTH     = DIV_WIDTH,
    parameter int OUT_WIDTH = DIV_OUT_WIDTH
) (
    input  logic          clk,
    input  logic          rst,
    mac_divider_if.slave  bus
);

    div_state_t           state_q, state_d;
    logic [OUT_WIDTH-1:0] dvd_q, dvd_d;
    logic [WIDTH-1:0]     dvs_q, dvs_d;
    logic [WIDTH:0]       rem_q, rem_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [OUT_WIDTH-1:0] quot_q, quot_d;
    logic [WIDTH-1:0]     res_rem_q, res_rem_d;
    logic                 dz_q, dz_d;
    logic                 ovf_q, ovf_d;

    logic [WIDTH:0]       step_rem;
    logic                 step_qbit;
    logic [OUT_WIDTH-1:0] quot_next;

    div_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .rem_i    (rem_q),
        .bit_i    (dvd_q[OUT_WIDTH-1]),
        .divisor_i(dvs_q),
        .rem_o    (step_rem),
        .qbit_o   (step_qbit)
    );

    // The dividend register doubles as the quotient register: dividend bits
    // leave at the top while quotient bits enter at the bottom.
    assign quot_next = {dvd_q[OUT_WIDTH-2:0], step_qbit};

    always_comb begin
        state_d   = state_q;
        dvd_d     = dvd_q;
        dvs_d     = dvs_q;
        rem_d     = rem_q;
        cnt_d     = cnt_q;
        quot_d    = quot_q;
        res_rem_d = res_rem_q;
        dz_d      = dz_q;
        ovf_d     = ovf_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    if (bus.B == '0) begin
                        quot_d    = '1;
                        res_rem_d = '0;
                        dz_d      = 1'b1;
                        ovf_d     = 1'b0;
                        state_d   = DONE;
                    end else begin
                        dvd_d   = bus.DATA_IN;
                        dvs_d   = bus.B;
                        rem_d   = '0;
                        cnt_d   = CNT_W'(OUT_WIDTH - 1);
                        state_d = CALC;
                    end
                end
            end
            CALC: begin
                rem_d = step_rem;
                dvd_d = quot_next;
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == '0) begin
                    // Results are registered on the last step so they are
                    // already valid in the cycle that done is high.
                    quot_d    = quot_next;
                    res_rem_d = step_rem[WIDTH-1:0];
                    dz_d      = 1'b0;
                    ovf_d     = |quot_next[OUT_WIDTH-1:WIDTH];
                    state_d   = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            dvd_q     <= '0;
            dvs_q     <= '0;
            rem_q     <= '0;
            cnt_q     <= '0;
            quot_q    <= '0;
            res_rem_q <= '0;
            dz_q      <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            dvd_q     <= dvd_d;
            dvs_q     <= dvs_d;
            rem_q     <= rem_d;
            cnt_q     <= cnt_d;
            quot_q    <= quot_d;
            res_rem_q <= res_rem_d;
            dz_q      <= dz_d;
            ovf_q     <= ovf_d;
        end
    end

    assign bus.Q        = quot_q;
    assign bus.R        = res_rem_q;
    assign bus.busy     = (state_q == CALC);
    assign bus.done     = (state_q == DONE);
    assign bus.div_zero = dz_q;
    assign bus.overflow = ovf_q;

endmodule
